// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming KxK convolution of a raster pixel stream against NUM_CH kernels.
// Build option CONV_RELU_EN clamps negative channel results to zero before they are registered.
module conv_stream_engine #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 2*DATA_W + $clog2(K*K)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          w_wr_en,
  input  logic [$clog2(NUM_CH*K*K)-1:0] w_addr,
  input  logic [DATA_W-1:0]             w_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*ACC_W-1:0]       out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);
  localparam int NW     = NUM_CH*K*K;
  localparam int AW     = $clog2(NW);
  localparam int TAPS   = (K-1)*IMG_W + K-1;
  localparam int TAPS_N = (TAPS > 0) ? TAPS : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W-1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H-1);
  localparam logic [COL_W-1:0] COL_KM1 = COL_W'(K-1);
  localparam logic [ROW_W-1:0] ROW_KM1 = ROW_W'(K-1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state_r, state_s;
  logic signed [DATA_W-1:0]   weight_r [NW];
  logic signed [DATA_W-1:0]   taps_r [TAPS_N];
  logic signed [DATA_W-1:0]   line_s [TAPS+1];
  logic signed [ACC_W-1:0]    acc_s [NUM_CH];
  logic [NUM_CH*ACC_W-1:0]    res_s;
  logic [NUM_CH*ACC_W-1:0]    out_data_r;
  logic [ROW_W-1:0]           row_r;
  logic [COL_W-1:0]           col_r;
  logic                       all_in_r, out_valid_r, out_last_r, done_r;
  logic                       in_ready_s, accept_s, out_hs_s, win_done_s, last_pix_s;

  // Full-precision product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  assign accept_s   = in_valid && in_ready_s;
  assign out_hs_s   = out_valid_r && out_ready;
  assign win_done_s = (row_r >= ROW_KM1) && (col_r >= COL_KM1);
  assign last_pix_s = (row_r == ROW_MAX) && (col_r == COL_MAX);

  // Next-state logic: a frame ends on the handshake of its last result.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (out_hs_s && out_last_r) state_s = IDLE;
        else                        state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Input flow control; the gate on all_in_r keeps stray pixels out once the frame is fully read.
  always_comb begin
    in_ready_s = 1'b0;
    if ((state_r == RUN) && !all_in_r) in_ready_s = !out_valid_r || out_ready;
    else                               in_ready_s = 1'b0;
  end

  // Tap 0 is the incoming pixel; tap d is the pixel accepted d acceptances earlier.
  always_comb begin
    line_s[0] = in_data;
    for (int n = 1; n <= TAPS; n++) line_s[n] = taps_r[n-1];
  end

  // Window pixel (i,j) sits (K-1-i) rows and (K-1-j) columns behind the incoming pixel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_s[c] = '0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          acc_s[c] = acc_s[c] + ext_prod(line_s[(K-1-i)*IMG_W + (K-1-j)], weight_r[c*K*K + i*K + j]);
        end
      end
    end
  end

  // Pack the channel sums into the output word.
  always_comb begin
    res_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef CONV_RELU_EN
      if (acc_s[c][ACC_W-1]) res_s[c*ACC_W +: ACC_W] = '0;
      else                   res_s[c*ACC_W +: ACC_W] = acc_s[c];
`else
      res_s[c*ACC_W +: ACC_W] = acc_s[c];
`endif
    end
  end

  // State register and the one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_r == RUN) && out_hs_s && out_last_r;
    end
  end

  // Weight store, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NW; w++) weight_r[w] <= '0;
    end else if ((state_r == IDLE) && w_wr_en && ({1'b0, w_addr} < (AW+1)'(NW))) begin
      weight_r[w_addr] <= w_data;
    end
  end

  // Line buffer shifts only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < TAPS_N; n++) taps_r[n] <= '0;
    end else if (accept_s) begin
      taps_r[0] <= in_data;
      for (int n = 1; n < TAPS_N; n++) taps_r[n] <= taps_r[n-1];
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r    <= '0;
      col_r    <= '0;
      all_in_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      row_r    <= '0;
      col_r    <= '0;
      all_in_r <= 1'b0;
    end else if (accept_s) begin
      if (col_r == COL_MAX) begin
        col_r <= '0;
        row_r <= (row_r == ROW_MAX) ? '0 : row_r + 1'b1;
      end else begin
        col_r <= col_r + 1'b1;
      end
      if (last_pix_s) all_in_r <= 1'b1;
    end
  end

  // One-deep output register, reloaded in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else if (accept_s && win_done_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= last_pix_s;
      out_data_r  <= res_s;
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r == RUN);
  assign done      = done_r;
endmodule
